// File: rtl/multiport_regfile_pkg.sv
// rtl/multiport_regfile_pkg.sv - shared defaults and helpers for the multi-port register file
package multiport_regfile_pkg;

  localparam int RF_DEF_DATA_W = 32;
  localparam int RF_DEF_ADDR_W = 5;
  localparam int RF_DEF_PEND_W = 2;
  localparam int RF_ZERO_REG   = 0;

  // Largest value a pending counter of width w can hold.
  function automatic int rf_pend_max(input int w);
    return (1 << w) - 1;
  endfunction

endpackage

// File: rtl/rf_pend_ctr.sv
// rtl/rf_pend_ctr.sv - saturating pending-writer counter for one register
module rf_pend_ctr
  import multiport_regfile_pkg::*;
#(
  parameter int PEND_W = RF_DEF_PEND_W,
  parameter int NWR_W  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inc,
  input  logic [NWR_W-1:0]  dec,
  output logic [PEND_W-1:0] cnt,
  output logic              full
);

  localparam int MAX   = rf_pend_max(PEND_W);
  localparam int SUM_W = ((PEND_W > NWR_W) ? PEND_W : NWR_W) + 1;

  logic [SUM_W-1:0] up;
  logic [SUM_W-1:0] nxt;

  // Claim is added before the writebacks are removed so a claim and a write
  // in the same cycle cancel; stray writebacks floor the count at zero.
  always_comb begin
    up  = SUM_W'(cnt) + SUM_W'(inc);
    nxt = '0;
    if (up > SUM_W'(dec)) begin
      nxt = up - SUM_W'(dec);
    end
    if (nxt > SUM_W'(MAX)) begin
      nxt = SUM_W'(MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else begin
      cnt <= nxt[PEND_W-1:0];
    end
  end

  assign full = (cnt == PEND_W'(MAX));

endmodule

// File: rtl/multiport_regfile.sv
// rtl/multiport_regfile.sv - multi-port register file with pending-write scoreboard; bypass via RF_BYPASS_EN
module multiport_regfile
  import multiport_regfile_pkg::*;
#(
  parameter int DATA_W = RF_DEF_DATA_W,
  parameter int ADDR_W = RF_DEF_ADDR_W,
  parameter int NUM_RD = 2,
  parameter int NUM_WR = 2,
  parameter int PEND_W = RF_DEF_PEND_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_WR-1:0]        we,
  input  logic [NUM_WR*ADDR_W-1:0] waddr,
  input  logic [NUM_WR*DATA_W-1:0] wdata,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     claim_valid,
  input  logic [ADDR_W-1:0]        claim_addr,
  output logic                     claim_ready
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam int NWR_W = $clog2(NUM_WR + 1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(RF_ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] wa  [NUM_WR];
  logic [DATA_W-1:0] wd  [NUM_WR];
  logic [NUM_WR-1:0] wv;
  logic [NWR_W-1:0]  nwr [DEPTH];
  logic [PEND_W-1:0] cnt [DEPTH];
  logic [DEPTH-1:0]  full;
  logic [DEPTH-1:1]  inc;

  always_comb begin
    for (int k = 0; k < NUM_WR; k++) begin
      wa[k] = waddr[k*ADDR_W +: ADDR_W];
      wd[k] = wdata[k*DATA_W +: DATA_W];
      wv[k] = we[k] && (wa[k] != ZERO_ADDR);
    end
  end

  // Number of writebacks landing on each register this cycle.
  always_comb begin
    for (int r = 0; r < DEPTH; r++) begin
      nwr[r] = '0;
      for (int k = 0; k < NUM_WR; k++) begin
        if (wv[k] && (wa[k] == ADDR_W'(r))) begin
          nwr[r] = nwr[r] + NWR_W'(1);
        end
      end
    end
  end

  // Ports are applied in ascending order so the highest index lands last.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < DEPTH; r++) begin
        mem[r] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (wv[k]) begin
          mem[wa[k]] <= wd[k];
        end
      end
    end
  end

  // A full counter still accepts a claim when a writeback frees a slot.
  assign claim_ready = (claim_addr == ZERO_ADDR) || !full[claim_addr] ||
                       (nwr[claim_addr] != '0);

  always_comb begin
    for (int r = 1; r < DEPTH; r++) begin
      inc[r] = claim_valid && claim_ready && (claim_addr == ADDR_W'(r));
    end
  end

  assign cnt[0]  = '0;
  assign full[0] = 1'b0;

  for (genvar r = 1; r < DEPTH; r++) begin : g_ctr
    rf_pend_ctr #(
      .PEND_W (PEND_W),
      .NWR_W  (NWR_W)
    ) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .inc  (inc[r]),
      .dec  (nwr[r]),
      .cnt  (cnt[r]),
      .full (full[r])
    );
  end

  always_comb begin : read_ports
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] val;
    rdata = '0;
    rbusy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra  = raddr[i*ADDR_W +: ADDR_W];
      val = mem[ra];
`ifdef RF_BYPASS_EN
      for (int k = 0; k < NUM_WR; k++) begin
        if (wv[k] && (wa[k] == ra)) begin
          val = wd[k];
        end
      end
      rbusy[i] = (ra != ZERO_ADDR) && (int'(cnt[ra]) > int'(nwr[ra]));
`else
      rbusy[i] = (ra != ZERO_ADDR) && ((cnt[ra] != '0) || (nwr[ra] != '0));
`endif
      if (ra == ZERO_ADDR) begin
        val = '0;
      end
      rdata[i*DATA_W +: DATA_W] = val;
    end
  end

endmodule
